fp_div_round_pack: RTL

- Downstream stage of the single-precision Goldschmidt divider.
- Consumes the raw quotient mantissa, the pre-computed biased exponent, the sign and the special-case classification from the divider.
- Normalizes, rounds to nearest-even, detects overflow/underflow and packs the IEEE-754 binary32 result with exception flags.
- Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/fp_div_round_pack.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_div_round_pack.sv
// Purpose : normalize, round-to-nearest-even, range-check and pack the Goldschmidt quotient into binary32.
// Latency : 2 cycles from input transfer to out_valid; throughput 1 per cycle.
// Backpres: each stage holds one entry and advances when the next is empty or draining; in_ready = !s1_valid || s1_advance.
//
// Ports:
//   clk, rst (async active-low)
//   in_valid/in_ready        upstream handshake
//   in_sign, in_exp, in_quot, in_sticky   raw quotient from the divider
//   in_nan, in_inf, in_zero  special-case classification (nan > inf > zero)
//   in_invalid, in_divzero   exception flags passed straight through
//   out_valid/out_ready      downstream handshake
//   out_result               packed binary32
//   out_flags                {invalid, divzero, overflow, underflow, inexact}
module fp_div_round_pack #(
    parameter int EXP_W  = 10,
    parameter int QUOT_W = 27
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [QUOT_W-1:0]       in_quot,
    input  logic                    in_sticky,
    input  logic                    in_nan,
    input  logic                    in_inf,
    input  logic                    in_zero,
    input  logic                    in_invalid,
    input  logic                    in_divzero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic [4:0]              out_flags
);

    localparam int EW1 = EXP_W + 1;

    // One extra exponent bit so that e-1 and e+1 can never wrap.
    localparam logic signed [EXP_W:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W:0] EXP_ONE  = EW1'(1);
    localparam logic signed [EXP_W:0] EXP_SAT  = EW1'(255);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s1_advance;
    logic in_fire;

    assign s1_advance = s1_valid && (!out_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1: normalize to a 1.xxx mantissa and make the round decision
    // ------------------------------------------------------------------
    logic signed [EXP_W:0] ext_exp;
    logic signed [EXP_W:0] n_exp;
    logic [22:0]           n_frac;     // hidden bit is implicit (always 1 for a normal result)
    logic                  n_lsb;
    logic                  n_guard;
    logic                  n_stk;
    logic                  n_malformed;
    logic                  n_inc;
    logic                  n_inexact;

    assign ext_exp = {in_exp[EXP_W-1], in_exp};

    always_comb begin
        n_exp       = ext_exp;
        n_frac      = '0;
        n_lsb       = 1'b0;
        n_guard     = 1'b0;
        n_stk       = 1'b0;
        n_malformed = 1'b0;
        if (in_quot[QUOT_W-1]) begin
            // quotient in [1,2): take 24 bits starting at the 2^0 position
            n_frac  = in_quot[QUOT_W-2 -: 23];
            n_lsb   = in_quot[QUOT_W-24];
            n_guard = in_quot[QUOT_W-25];
            n_stk   = (|in_quot[QUOT_W-26:0]) | in_sticky;
        end else if (in_quot[QUOT_W-2]) begin
            // quotient in [0.5,1): shift left by one, one less exponent
            n_frac  = in_quot[QUOT_W-3 -: 23];
            n_lsb   = in_quot[QUOT_W-25];
            n_guard = in_quot[QUOT_W-26];
            n_stk   = (|in_quot[QUOT_W-27:0]) | in_sticky;
            n_exp   = ext_exp - EXP_ONE;
        end else begin
            // Divider never produces a quotient below 0.5; treat as zero.
            n_malformed = 1'b1;
        end
    end

    assign n_inc     = n_guard & (n_stk | n_lsb);
    assign n_inexact = n_guard | n_stk;

    logic                  s1_sign;
    logic signed [EXP_W:0] s1_exp;
    logic [22:0]           s1_frac;
    logic                  s1_inc;
    logic                  s1_inexact;
    logic                  s1_nan;
    logic                  s1_inf;
    logic                  s1_zero;
    logic                  s1_invalid;
    logic                  s1_divzero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_frac    <= '0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
            s1_invalid <= 1'b0;
            s1_divzero <= 1'b0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_sign    <= in_sign;
            s1_exp     <= n_exp;
            s1_frac    <= n_frac;
            s1_inc     <= n_inc;
            s1_inexact <= n_inexact;
            s1_nan     <= in_nan;
            s1_inf     <= in_inf;
            s1_zero    <= in_zero | n_malformed;
            s1_invalid <= in_invalid;
            s1_divzero <= in_divzero;
        end else if (s1_advance) begin
            s1_valid   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: apply the increment, range-check and pack
    // ------------------------------------------------------------------
    logic [22:0]           r_frac;
    logic                  r_carry;
    logic signed [EXP_W:0] r_exp;
    logic                  uflow;
    logic [31:0]           p_result;
    logic                  p_ovf;
    logic                  p_unf;
    logic                  p_inx;

    // Carry out of the fraction means the 1.111..1 mantissa rolled to 2.0;
    // the fraction bits are then all zero and the exponent bumps by one.
    assign {r_carry, r_frac} = 24'({1'b0, s1_frac}) + 24'(s1_inc);
    assign r_exp             = s1_exp + $signed({{EXP_W{1'b0}}, r_carry});
    assign uflow             = (s1_exp <= EXP_ZERO);

    always_comb begin
        p_result = {s1_sign, s1_exp[7:0] + {7'b0, r_carry}, r_frac};
        p_ovf    = 1'b0;
        p_unf    = 1'b0;
        p_inx    = s1_inexact;
        if (s1_nan) begin
            p_result = 32'h7FC0_0000;
            p_inx    = 1'b0;
        end else if (s1_inf) begin
            p_result = {s1_sign, 8'hFF, 23'h0};
            p_inx    = 1'b0;
        end else if (s1_zero) begin
            p_result = {s1_sign, 31'h0};
            p_inx    = 1'b0;
        end else if (uflow) begin
            // Flush-to-zero; decided on the pre-round exponent.
            p_result = {s1_sign, 31'h0};
            p_unf    = 1'b1;
            p_inx    = 1'b1;
        end else if (r_exp >= EXP_SAT) begin
            p_result = {s1_sign, 8'hFF, 23'h0};
            p_ovf    = 1'b1;
            p_inx    = 1'b1;
        end else begin
            p_result = {s1_sign, r_exp[7:0], r_frac};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s1_advance) begin
            out_valid  <= 1'b1;
            out_result <= p_result;
            out_flags  <= {s1_invalid, s1_divzero, p_ovf, p_unf, p_inx};
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
